// File: rtl/parity_pkg.sv
// Shared helpers for the XOR-reduction parity scheme.
// Used by the generator and the stream checker.
package parity_pkg;

   localparam int unsigned PARITY_EVEN       = 0;
   localparam int unsigned PARITY_ODD_SCHEME = 1;

   // Operands are zero-extended to 64 bits; extension leaves XOR parity unchanged.
   function automatic logic parity_of(input logic [63:0] data);
      return ^data;
   endfunction

   function automatic logic [63:0] sat_inc(input logic [63:0] count, input int unsigned width);
      logic [63:0] w_max;
      w_max = {64{1'b1}} >> (64 - width);
      return (count == w_max) ? count : count + 64'd1;
   endfunction

endpackage

// File: rtl/parity_check_stream_gen.sv
// Parity generator: even-parity bit of a data word.
// The bit is 1 iff the word has an odd number of ones.
module parity_check_stream_gen
   import parity_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_data,
   output logic             o_parity
);

   assign o_parity = parity_of(64'(i_data));

endmodule

// File: rtl/parity_check_stream.sv
// Receive-side parity checker with a one-word pipeline register.
// It tags each word with a mismatch flag and keeps sticky and counted error status.
module parity_check_stream
   import parity_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned PARITY_ODD = 0,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_parity,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_err,
   output logic                 err_sticky,
   input  logic                 err_clr,
   output logic [CNT_WIDTH-1:0] err_count
);

   localparam logic LpInvert = (PARITY_ODD == PARITY_ODD_SCHEME);

   logic                 r_out_valid;
   logic [WIDTH-1:0]     r_out_data;
   logic                 r_out_err;
   logic                 r_err_sticky;
   logic [CNT_WIDTH-1:0] r_err_count;

   logic                 w_par;
   logic                 w_mism;
   logic                 w_accept;
   logic                 w_deliver;
   logic                 w_err_acc;
   logic [CNT_WIDTH-1:0] w_cnt_inc;

   parity_check_stream_gen #(
      .WIDTH (WIDTH)
   ) u_gen (
      .i_data   (in_data),
      .o_parity (w_par)
   );

   assign w_mism    = w_par ^ in_parity ^ LpInvert;
   assign in_ready  = !rst && (!r_out_valid || out_ready);
   assign w_accept  = in_valid && in_ready;
   assign w_deliver = r_out_valid && out_ready;
   assign w_err_acc = w_accept && w_mism;
   assign w_cnt_inc = CNT_WIDTH'(sat_inc(64'(r_err_count), CNT_WIDTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_err   <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_data  <= in_data;
         r_out_err   <= w_mism;
      end else if (w_deliver) begin
         r_out_valid <= 1'b0;
      end
   end

   // A clear coinciding with an error accept still records that new error.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_sticky <= 1'b0;
         r_err_count  <= '0;
      end else if (err_clr) begin
         r_err_sticky <= w_err_acc;
         r_err_count  <= w_err_acc ? CNT_WIDTH'(1) : '0;
      end else if (w_err_acc) begin
         r_err_sticky <= 1'b1;
         r_err_count  <= w_cnt_inc;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_err    = r_out_err;
   assign err_sticky = r_err_sticky;
   assign err_count  = r_err_count;

endmodule

// File: tb/tb_parity_check_stream.sv
// Bench: three checker configurations share one stimulus stream.
// A behavioural model predicts every output in every cycle.
module tb_parity_check_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_parity;
   logic       out_ready;
   logic       err_clr;

   logic [2:0]  ir, ov, oe, st;
   logic [7:0]  od [3];
   logic [15:0] cnt0, cnt2;
   logic [1:0]  cnt1;

   int n_checks = 0;
   int n_errors = 0;

   // Model state; instances are 0 default, 1 CNT_WIDTH=2, 2 PARITY_ODD=1.
   int unsigned cmax [3];
   int          odd_cfg [3];
   bit          m_valid;
   int unsigned m_data;
   bit          m_err [3];
   int unsigned m_cnt [3];
   bit          m_sticky [3];

   always #5 clk = ~clk;

   parity_check_stream #(.WIDTH(8), .PARITY_ODD(0), .CNT_WIDTH(16)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
      .in_parity(in_parity), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
      .out_err(oe[0]), .err_sticky(st[0]), .err_clr(err_clr), .err_count(cnt0)
   );

   parity_check_stream #(.WIDTH(8), .PARITY_ODD(0), .CNT_WIDTH(2)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
      .in_parity(in_parity), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
      .out_err(oe[1]), .err_sticky(st[1]), .err_clr(err_clr), .err_count(cnt1)
   );

   parity_check_stream #(.WIDTH(8), .PARITY_ODD(1), .CNT_WIDTH(16)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
      .in_parity(in_parity), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
      .out_err(oe[2]), .err_sticky(st[2]), .err_clr(err_clr), .err_count(cnt2)
   );

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Transmitted bit should equal (number of ones mod 2), flipped for the odd scheme.
   function automatic bit model_mism(input int i, input int unsigned d, input bit p);
      int unsigned expect_p;
      expect_p = ($countones(d) % 2 + odd_cfg[i]) % 2;
      return int'(p) != int'(expect_p);
   endfunction

   task automatic cycle();
      int unsigned obs_cnt [3];
      bit acc;
      bit n_valid;
      int unsigned n_data;
      bit e;
      @(negedge clk);
      obs_cnt[0] = cnt0;
      obs_cnt[1] = cnt1;
      obs_cnt[2] = cnt2;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("in_ready[%0d]", i), ir[i], (!rst && (!m_valid || out_ready)) ? 1 : 0);
         check($sformatf("out_valid[%0d]", i), ov[i], m_valid);
         check($sformatf("out_data[%0d]", i), od[i], m_data);
         check($sformatf("out_err[%0d]", i), oe[i], m_err[i]);
         check($sformatf("err_sticky[%0d]", i), st[i], m_sticky[i]);
         check($sformatf("err_count[%0d]", i), obs_cnt[i], m_cnt[i]);
      end
      acc = !rst && in_valid && (!m_valid || out_ready);
      n_valid = m_valid;
      n_data = m_data;
      @(posedge clk);
      if (rst) begin
         m_valid = 0;
         m_data  = 0;
         for (int i = 0; i < 3; i++) begin
            m_err[i] = 0;
            m_cnt[i] = 0;
            m_sticky[i] = 0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            e = acc && model_mism(i, in_data, in_parity);
            if (acc) m_err[i] = model_mism(i, in_data, in_parity);
            if (err_clr) begin
               m_cnt[i] = e ? 1 : 0;
               m_sticky[i] = e;
            end else if (e) begin
               m_cnt[i] = (m_cnt[i] < cmax[i]) ? m_cnt[i] + 1 : cmax[i];
               m_sticky[i] = 1;
            end
         end
         if (acc) begin
            m_valid = 1;
            m_data  = in_data;
         end else if (n_valid && out_ready) begin
            m_valid = 0;
         end
      end
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic p);
      in_valid  = 1'b1;
      in_data   = d;
      in_parity = p;
      cycle();
   endtask

   initial begin
      cmax    = '{65535, 3, 65535};
      odd_cfg = '{0, 0, 1};
      m_valid = 0;
      m_data  = 0;
      for (int i = 0; i < 3; i++) begin
         m_err[i] = 0;
         m_cnt[i] = 0;
         m_sticky[i] = 0;
      end
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_parity = 1'b0;
      out_ready = 1'b1; err_clr = 1'b0;
      @(posedge clk);
      #1;
      cycle();
      rst = 1'b0;
      cycle();

      // Clean stream, then one mismatch and one good word.
      send(8'hA5, 1'b0);
      send(8'h01, 1'b1);
      send(8'h03, 1'b0);
      send(8'h07, 1'b0);
      send(8'hFF, 1'b0);
      in_valid = 1'b0;
      cycle();

      // Stall with 0x3C held while 0x11 waits.
      out_ready = 1'b0;
      send(8'h3C, 1'b0);
      for (int k = 0; k < 5; k++) send(8'h11, 1'b0);
      out_ready = 1'b1;
      send(8'h11, 1'b0);
      in_valid = 1'b0;
      cycle();
      cycle();

      // Saturation on the 2-bit counter.
      for (int k = 0; k < 5; k++) send(8'h07, 1'b0);
      in_valid = 1'b0;
      cycle();
      check("sat_cnt1", cnt1, 2'd3);

      // Clear together with an error accept, then clear alone.
      err_clr = 1'b1;
      send(8'h07, 1'b0);
      err_clr = 1'b0;
      in_valid = 1'b0;
      cycle();
      check("clr_err_cnt1", cnt1, 1);
      check("clr_err_sticky1", st[1], 1);
      err_clr = 1'b1;
      cycle();
      err_clr = 1'b0;
      cycle();
      check("clr_cnt1", cnt1, 0);

      // Odd-scheme words, then reset while full with a bad word offered.
      send(8'hA5, 1'b1);
      send(8'hA5, 1'b0);
      out_ready = 1'b0;
      rst = 1'b1;
      send(8'h07, 1'b0);
      cycle();
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      cycle();

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         in_valid  = 1'($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         in_parity = 1'($urandom);
         out_ready = 1'($urandom_range(0, 3) != 0);
         err_clr   = 1'($urandom_range(0, 19) == 0);
         rst       = 1'($urandom_range(0, 99) == 0);
         cycle();
      end
      rst = 1'b0; in_valid = 1'b0; err_clr = 1'b0;
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
